// File: rtl/collatz_sweep_if.sv
// collatz_sweep_if: valid/ready request/response link between the sweep initiator and a single-input/single-output core
// master: drives core_in_valid, core_in0 and core_out_ready; slave: drives core_in_ready, core_out_valid and core_out0
`timescale 1ns/1ps
interface collatz_sweep_if #(parameter int N = 16) ();
  logic         core_in_valid;
  logic         core_in_ready;
  logic [N-1:0] core_in0;
  logic         core_out_valid;
  logic         core_out_ready;
  logic [N-1:0] core_out0;
  modport master (
    output core_in_valid, core_in0, core_out_ready,
    input  core_in_ready, core_out_valid, core_out0
  );
  modport slave (
    input  core_in_valid, core_in0, core_out_ready,
    output core_in_ready, core_out_valid, core_out0
  );
endinterface

// File: rtl/collatz_sweep.sv
// collatz_sweep: sweeps seeds lo..hi through a core, one request at a time, and tracks the seed with the largest result
// clk/rst: clock and synchronous active-high reset
// start/lo/hi: begin a sweep over seeds lo..hi inclusive (sampled only when idle)
// busy/done: sweep in progress / one-cycle end-of-sweep pulse
// best_seed/best_steps/count: winning seed, its result, responses accepted
// bus: master side of the core request/response link
// error: watchdog expiry flag, present only when COLLATZ_SWEEP_TIMEOUT_EN is defined
`timescale 1ns/1ps
module collatz_sweep #(
  parameter int N       = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         lo,
  input  logic [N-1:0]         hi,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         best_seed,
  output logic [N-1:0]         best_steps,
  output logic [N-1:0]         count,
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
  output logic                 error,
`endif
  collatz_sweep_if.master      bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t       state_q;
  logic [N-1:0] cur_q, hi_q, in0_q, best_seed_q, best_steps_q, count_q;
  logic [N-1:0] cur_d;
  logic         in_valid_q, busy_q, done_q;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q;
  logic          error_q;
  assign error = error_q;
`endif
  // seed 0 is never issued, so the sweep starts at 1 at the lowest
  assign cur_d              = (lo == '0) ? N'(1) : lo;
  assign bus.core_in_valid  = in_valid_q;
  assign bus.core_in0       = in0_q;
  assign bus.core_out_ready = (state_q == IDLE) || (state_q == WAIT);
  assign busy               = busy_q;
  assign done               = done_q;
  assign best_seed          = best_seed_q;
  assign best_steps         = best_steps_q;
  assign count              = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      hi_q         <= '0;
      in0_q        <= '0;
      in_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_seed_q  <= '0;
      best_steps_q <= '0;
      count_q      <= '0;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
      wd_q         <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          hi_q         <= hi;
          cur_q        <= cur_d;
          in0_q        <= cur_d;
          best_seed_q  <= '0;
          best_steps_q <= '0;
          count_q      <= '0;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
          error_q      <= 1'b0;
`endif
          // comparing the clamped start also makes lo=hi=0 an empty sweep
          if (cur_d > hi) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            in_valid_q <= 1'b1;
          end
        end
        ISSUE: if (bus.core_in_ready) begin
          state_q    <= WAIT;
          in_valid_q <= 1'b0;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
          wd_q       <= '0;
`endif
        end
        WAIT: begin
          if (bus.core_out_valid) begin
            count_q <= (&count_q) ? count_q : count_q + 1'b1;
            if (bus.core_out0 > best_steps_q) begin
              best_seed_q  <= cur_q;
              best_steps_q <= bus.core_out0;
            end
            // test for the last seed before incrementing so hi=all-ones cannot wrap
            if (cur_q == hi_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cur_q      <= cur_q + 1'b1;
              in0_q      <= cur_q + 1'b1;
              in_valid_q <= 1'b1;
              state_q    <= ISSUE;
            end
          end
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
          else if (wd_q == WW'(TIMEOUT - 1)) begin
            error_q <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else wd_q <= wd_q + 1'b1;
`endif
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
